// File: rtl/unidade_controle_niveis_if.sv
// Datapath bus between the level control unit and the ROM/play-register datapath.
//   endereco             ROM address (LED index while showing, play index otherwise)
//   liga_led             drive ROM value onto the LEDs
//   registraR / zeraR    load / clear the play register
//   fez_jogada           a play is present on the keys
//   jogada_igual_memoria registered play equals ROM at endereco
// master = control unit, slave = datapath.
interface unidade_controle_niveis_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] endereco;
  logic              liga_led;
  logic              registraR;
  logic              zeraR;
  logic              fez_jogada;
  logic              jogada_igual_memoria;

  modport master (
    output endereco, liga_led, registraR, zeraR,
    input  fez_jogada, jogada_igual_memoria
  );

  modport slave (
    input  endereco, liga_led, registraR, zeraR,
    output fez_jogada, jogada_igual_memoria
  );
endinterface

// File: rtl/unidade_controle_niveis.sv
// Control unit for the memory game. Owns the level, play, LED-index,
// LED-timer and timeout counters; plays the sequence back on the LEDs,
// collects plays, keeps score and remaining lives.
//   clock, reset    system clock, async active-high reset
//   iniciar         start / restart request
//   modo            0 = fixed full-length sequence, 1 = progressive
//   bus             datapath bus (master side)
//   nivel           current level index
//   score           correct plays this game (saturating)
//   vidas           lives remaining
//   pronto, acertou, errou, timeout  end-of-game flags
//   db_estado       state code
module unidade_controle_niveis #(
  parameter int ADDR_W         = 4,
  parameter int N_LEVELS       = 16,
  parameter int LED_ON_CYCLES  = 1000,
  parameter int LED_OFF_CYCLES = 500,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int LIVES          = 3,
  parameter int SCORE_W        = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic                 modo,
  unidade_controle_niveis_if.master bus,
  output logic [ADDR_W-1:0]    nivel,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           vidas,
  output logic                 pronto,
  output logic                 acertou,
  output logic                 errou,
  output logic                 timeout,
  output logic [3:0]           db_estado
);

  localparam int LT_W = $clog2(LED_ON_CYCLES + LED_OFF_CYCLES + 1);
  localparam int TT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [LT_W-1:0]    LED_ON_LAST  = LT_W'(LED_ON_CYCLES - 1);
  localparam logic [LT_W-1:0]    LED_OFF_LAST = LT_W'(LED_ON_CYCLES + LED_OFF_CYCLES - 1);
  localparam logic [TT_W-1:0]    TO_LAST      = TT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0]  NIVEL_MAX    = ADDR_W'(N_LEVELS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;
  localparam logic [3:0]         VIDAS_INI    = 4'(LIVES);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    LIGA_LED    = 4'h2,
    DESLIGA_LED = 4'h3,
    AVANCA_LED  = 4'h4,
    AGUARDA     = 4'h5,
    REGISTRA    = 4'h6,
    COMPARA     = 4'h7,
    PROX_JOGADA = 4'h8,
    PROX_NIVEL  = 4'h9,
    ACERTOU     = 4'hA,
    ERROU       = 4'hB,
    PERDE_VIDA  = 4'hC,
    TIMEOUT     = 4'hD
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] jogada;
  logic [ADDR_W-1:0] led_idx;
  logic [LT_W-1:0]   led_tmr;
  logic [TT_W-1:0]   to_tmr;

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= INICIAL;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      INICIAL:     if (iniciar) state_nxt = PREPARACAO;
      PREPARACAO:  state_nxt = LIGA_LED;
      LIGA_LED:    if (led_tmr == LED_ON_LAST) state_nxt = DESLIGA_LED;
      DESLIGA_LED: if (led_tmr == LED_OFF_LAST)
                     state_nxt = (led_idx < nivel) ? AVANCA_LED : AGUARDA;
      AVANCA_LED:  state_nxt = LIGA_LED;
      // timeout wins over a play arriving in the very last cycle
      AGUARDA:     if (to_tmr == TO_LAST)   state_nxt = TIMEOUT;
                   else if (bus.fez_jogada) state_nxt = REGISTRA;
      REGISTRA:    state_nxt = COMPARA;
      COMPARA: begin
        if (!bus.jogada_igual_memoria) state_nxt = PERDE_VIDA;
        else if (jogada < nivel)       state_nxt = PROX_JOGADA;
        else if (nivel == NIVEL_MAX)   state_nxt = ACERTOU;
        else                           state_nxt = PROX_NIVEL;
      end
      PROX_JOGADA: state_nxt = AGUARDA;
      PROX_NIVEL:  state_nxt = PREPARACAO;
      PERDE_VIDA:  state_nxt = (vidas <= 4'd1) ? ERROU : PREPARACAO;
      ACERTOU, ERROU, TIMEOUT: if (iniciar) state_nxt = INICIAL;
      default:     state_nxt = INICIAL;
    endcase
  end

  // Moore outputs
  always_comb begin
    bus.liga_led  = 1'b0;
    bus.registraR = 1'b0;
    bus.zeraR     = 1'b0;
    pronto        = 1'b0;
    acertou       = 1'b0;
    errou         = 1'b0;
    timeout       = 1'b0;
    bus.endereco  = jogada;
    db_estado     = state;
    case (state)
      INICIAL, PREPARACAO, PROX_JOGADA, PROX_NIVEL: bus.zeraR = 1'b1;
      LIGA_LED: begin
        bus.liga_led = 1'b1;
        bus.endereco = led_idx;
      end
      DESLIGA_LED, AVANCA_LED: bus.endereco = led_idx;
      REGISTRA: bus.registraR = 1'b1;
      ACERTOU: begin pronto = 1'b1; acertou = 1'b1; end
      ERROU:   begin pronto = 1'b1; errou   = 1'b1; end
      TIMEOUT: begin pronto = 1'b1; timeout = 1'b1; end
      default: ;
    endcase
  end

  // Counters. Each one only moves in the states that own it, and every
  // path out of its range leaves the state first, so none can wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nivel   <= '0;
      jogada  <= '0;
      led_idx <= '0;
      led_tmr <= '0;
      to_tmr  <= '0;
      score   <= '0;
      vidas   <= VIDAS_INI;
    end else begin
      case (state)
        INICIAL: begin
          jogada  <= '0;
          led_idx <= '0;
          led_tmr <= '0;
          to_tmr  <= '0;
          // modo only matters here: it picks the starting level
          if (iniciar) begin
            nivel <= modo ? '0 : NIVEL_MAX;
            vidas <= VIDAS_INI;
            score <= '0;
          end else begin
            nivel <= '0;
          end
        end
        PREPARACAO: begin
          jogada  <= '0;
          led_idx <= '0;
          led_tmr <= '0;
        end
        LIGA_LED:    led_tmr <= led_tmr + 1'b1;
        DESLIGA_LED: begin
          led_tmr <= led_tmr + 1'b1;
          to_tmr  <= '0;
        end
        AVANCA_LED: begin
          led_idx <= led_idx + 1'b1;
          led_tmr <= '0;
        end
        AGUARDA:  to_tmr <= to_tmr + 1'b1;
        REGISTRA: to_tmr <= '0;
        COMPARA:  if (bus.jogada_igual_memoria && score != SCORE_MAX)
                    score <= score + 1'b1;
        PROX_JOGADA: jogada <= jogada + 1'b1;
        PROX_NIVEL:  nivel  <= nivel + 1'b1;
        PERDE_VIDA:  if (vidas != 4'd0) vidas <= vidas - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle_niveis.sv
module tb_unidade_controle_niveis;
  localparam int AW   = 2;
  localparam int NL   = 4;
  localparam int LON  = 3;
  localparam int LOFF = 2;
  localparam int TO   = 10;
  localparam int LV   = 2;

  logic clock = 1'b0;
  logic reset, iniciar, modo, fez, igual;
  logic [AW-1:0] nivel, nivel_s;
  logic [7:0]    score;
  logic [1:0]    score_s;
  logic [3:0]    vidas, vidas_s, db_estado, db_estado_s;
  logic pronto, acertou, errou, timeout;
  logic pronto_s, acertou_s, errou_s, timeout_s;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  unidade_controle_niveis_if #(.ADDR_W(AW)) bus ();
  unidade_controle_niveis_if #(.ADDR_W(AW)) bus_s ();

  assign bus.fez_jogada             = fez;
  assign bus.jogada_igual_memoria   = igual;
  assign bus_s.fez_jogada           = fez;
  assign bus_s.jogada_igual_memoria = igual;

  unidade_controle_niveis #(.ADDR_W(AW), .N_LEVELS(NL), .LED_ON_CYCLES(LON),
    .LED_OFF_CYCLES(LOFF), .TIMEOUT_CYCLES(TO), .LIVES(LV), .SCORE_W(8)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo), .bus(bus),
    .nivel(nivel), .score(score), .vidas(vidas), .pronto(pronto),
    .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado));

  // narrow-score copy, fed the same stimulus, to see saturation
  unidade_controle_niveis #(.ADDR_W(AW), .N_LEVELS(NL), .LED_ON_CYCLES(LON),
    .LED_OFF_CYCLES(LOFF), .TIMEOUT_CYCLES(TO), .LIVES(LV), .SCORE_W(2)) dut_s (
    .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo), .bus(bus_s),
    .nivel(nivel_s), .score(score_s), .vidas(vidas_s), .pronto(pronto_s),
    .acertou(acertou_s), .errou(errou_s), .timeout(timeout_s), .db_estado(db_estado_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_state(input string tag, input int exp);
    chk(tag, db_estado, exp);
    chk({tag, "_s"}, db_estado_s, exp);
  endtask

  // 0 correct, 1 wrong, 2 let it time out, 3 play on the last allowed cycle
  function automatic int decide(input int policy, input int lvl, input int j);
    int r;
    case (policy)
      1: return 0;
      2: return (lvl == 1 && j == 0) ? 1 : 0;
      3: return 2;
      4: return 3;
      default: begin
        r = $urandom_range(0, 99);
        if (r < 80) return 0;
        if (r < 92) return 1;
        if (r < 96) return 2;
        return 3;
      end
    endcase
  endfunction

  // Follow one LED playback: lvl+1 pulses, addresses 0..lvl, LON cycles each.
  task automatic watch_show(input int lvl);
    int cnt = 0;
    int run = 0;
    int guard = 0;
    while (db_estado != 4'd5 && guard < 200) begin
      if (bus.liga_led) begin
        if (run == 0) chk("led_addr", bus.endereco, cnt);
        run++;
      end else if (run > 0) begin
        chk("led_on_len", run, LON);
        run = 0;
        cnt++;
      end
      tick();
      guard++;
    end
    chk_state("show_end", 5);
    chk("led_count", cnt, lvl + 1);
  endtask

  task automatic play_game(input bit m, input int policy);
    int lvl, sc, lives, res, j, act, d;
    bit done, round;
    lvl = m ? 0 : NL - 1;
    sc = 0; lives = LV; res = 0; done = 0;
    chk_state("inicial", 0);
    modo = m; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    modo = 1'($urandom);   // must not matter after the start
    chk_state("prep", 1);
    chk("zeraR_prep", bus.zeraR, 1);
    chk("nivel_start", nivel, lvl);
    chk("score_start", score, 0);
    chk("vidas_start", vidas, LV);
    while (!done) begin
      watch_show(lvl);
      j = 0; round = 1;
      while (round) begin
        chk("play_addr", bus.endereco, j);
        chk("nivel", nivel, lvl);
        act = decide(policy, lvl, j);
        if (act >= 2) begin
          repeat (TO - 1) tick();
          chk_state("aguarda_hold", 5);
          if (act == 3) begin fez = 1'b1; igual = 1'b1; end
          tick();
          fez = 1'b0;
          chk_state("timeout_st", 13);
          res = 13; done = 1; round = 0;
        end else begin
          d = $urandom_range(0, TO - 2);
          repeat (d) tick();
          fez = 1'b1; igual = (act == 0);
          tick();
          fez = 1'b0;
          chk_state("registra", 6);
          chk("registraR", bus.registraR, 1);
          tick();
          chk_state("compara", 7);
          tick();
          if (act == 0) begin
            sc++;
            if (j < lvl) begin
              chk_state("prox_jogada", 8);
              tick();
              chk_state("back_aguarda", 5);
              j++;
            end else if (lvl == NL - 1) begin
              res = 10; done = 1; round = 0;
            end else begin
              chk_state("prox_nivel", 9);
              lvl++; round = 0;
            end
          end else begin
            chk_state("perde_vida", 12);
            lives--;
            tick();
            chk("vidas_dec", vidas, lives);
            if (lives == 0) begin
              res = 11; done = 1;
            end else begin
              chk_state("replay", 1);
            end
            round = 0;
          end
          chk("score", score, sc);
          chk("score_sat", score_s, (sc > 3) ? 3 : sc);
        end
      end
    end
    chk_state("final", res);
    chk("pronto", pronto, 1);
    chk("acertou", acertou, res == 10);
    chk("errou", errou, res == 11);
    chk("timeout", timeout, res == 13);
    chk("pronto_s", pronto_s, 1);
    chk("flags_s", {acertou_s, errou_s, timeout_s}, {res == 10, res == 11, res == 13});
    chk("final_score", score, sc);
    chk("final_vidas", vidas, lives);
    chk("final_vidas_s", vidas_s, lives);
    chk("final_nivel", nivel, lvl);
    chk("final_nivel_s", nivel_s, lvl);
    repeat (3) tick();
    chk_state("terminal_hold", res);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk_state("restart", 0);
    chk("kept_score", score, sc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    reset = 1'b1; iniciar = 1'b0; modo = 1'b0; fez = 1'b0; igual = 1'b0;
    tick(); tick();
    chk_state("rst_state", 0);
    chk("rst_vidas", vidas, LV);
    chk("rst_score", score, 0);
    chk("rst_nivel", nivel, 0);
    chk("rst_addr", bus.endereco, 0);
    chk("rst_flags", {pronto, acertou, errou, timeout, bus.liga_led, bus.registraR}, 0);
    reset = 1'b0;
    tick();

    play_game(1'b1, 1);   // progressive, all correct: score 10
    play_game(1'b0, 1);   // fixed, all correct: score 4, nivel 3
    play_game(1'b1, 2);   // wrong twice at level 1: ERROU
    play_game(1'b1, 3);   // idle in AGUARDA: TIMEOUT
    play_game(1'b0, 4);   // play on the last cycle: still TIMEOUT
    for (int g = 0; g < 12; g++) play_game(1'($urandom), 0);

    // async reset in the middle of an LED
    modo = 1'b1; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    guard = 0;
    while (!bus.liga_led && guard < 20) begin tick(); guard++; end
    chk("led_seen", bus.liga_led, 1);
    tick();
    reset = 1'b1;
    #1;
    chk_state("async_rst", 0);
    chk("async_led", bus.liga_led, 0);
    chk("async_vidas", vidas, LV);
    tick();
    reset = 1'b0;
    tick();
    chk_state("after_rst", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
